wallace_divider: RTL and testbench

Sequential 64-by-32 unsigned divider undoing the 32x32 Wallace multiplier: a 64-bit product and one 32-bit factor return the other factor and a remainder. Radix-2 restoring, one quotient bit per clock. Valid/ready handshake on input and output. Sits beside the multiplier in the arithmetic datapath and doubles as its self-check partner (product / b == a, remainder 0).

---
 rtl/wallace_divider.sv | 111 +++++++++++
 tb/tb_wallace_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wallace_divider.sv
// 64-by-32 unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Inverts the 32x32 Wallace multiplier: product / factor returns the other factor with remainder 0.
module wallace_divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_zero,
   output logic               overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;
   logic             r_dz;
   logic             r_ov;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dz_out;
   logic             r_ov_out;

   logic [WIDTH:0]   w_t;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;

   // R < D holds every step, so T < 2D and T - D always fits in WIDTH bits.
   assign w_t      = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_t >= {1'b0, r_div});
   assign w_diff   = w_t[WIDTH-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_diff : w_t[WIDTH-1:0];
   assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_dz     <= 1'b0;
         r_ov     <= 1'b0;
         r_q_out  <= '0;
         r_r_out  <= '0;
         r_dz_out <= 1'b0;
         r_ov_out <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_rem   <= dividend[2*WIDTH-1:WIDTH];
                  r_quo   <= dividend[WIDTH-1:0];
                  r_div   <= divisor;
                  r_cnt   <= '0;
                  r_dz    <= (divisor == '0);
                  r_ov    <= (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
                  r_state <= RUN;
               end
            end
            RUN: begin
               // Exceptions spend exactly one RUN cycle so their result lands one edge after accept.
               if (r_dz || r_ov) begin
                  r_q_out  <= '1;
                  r_r_out  <= r_quo;
                  r_dz_out <= r_dz;
                  r_ov_out <= r_ov;
                  r_state  <= DONE;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(WIDTH-1)) begin
                     r_q_out  <= w_quo_nx;
                     r_r_out  <= w_rem_nx;
                     r_dz_out <= 1'b0;
                     r_ov_out <= 1'b0;
                     r_state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign quotient  = r_q_out;
   assign remainder = r_r_out;
   assign div_zero  = r_dz_out;
   assign overflow  = r_ov_out;

endmodule

// File: tb/tb_wallace_divider.sv
// Directed checks of wallace_divider: latency, exceptions, backpressure, reset abort, plus seeded vectors.
module tb_wallace_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   wallace_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input string tag, input logic [63:0] dd, input logic [31:0] dv);
      int n = 0;
      while (!in_ready && n < 100) begin tick; n++; end
      chk($sformatf("%s.rdy", tag), in_ready, 1);
      dividend = dd; divisor = dv; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin tick; cyc++; end
   endtask

   task automatic run(input string tag, input logic [63:0] dd, input logic [31:0] dv,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz,
                      input logic eov, input int elat, input int hold);
      int cyc;
      start(tag, dd, dv);
      wait_done(cyc);
      chk($sformatf("%s.lat", tag), cyc, elat);
      chk($sformatf("%s.q", tag), quotient, eq);
      chk($sformatf("%s.r", tag), remainder, er);
      chk($sformatf("%s.dz", tag), div_zero, edz);
      chk($sformatf("%s.ov", tag), overflow, eov);
      if (hold > 0) begin
         out_ready = 1'b0;
         repeat (hold) tick;
         chk($sformatf("%s.hv", tag), {out_valid, in_ready}, 2'b10);
         chk($sformatf("%s.hq", tag), {quotient, remainder}, {eq, er});
         out_ready = 1'b1;
      end
      tick;
      chk($sformatf("%s.drop", tag), {out_valid, in_ready}, 2'b01);
   endtask

   typedef struct {
      logic [63:0] dd;
      logic [31:0] dv;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      logic        ov;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cyc;
      vecs[0] = '{64'd3800, 32'd95, 32'd40, 32'd0, 1'b0, 1'b0, 32};
      vecs[1] = '{64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 32};
      vecs[2] = '{64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 32};
      vecs[3] = '{64'd123, 32'd0, 32'hFFFFFFFF, 32'd123, 1'b1, 1'b0, 1};
      vecs[4] = '{64'h1_00000000, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1};
      vecs[5] = '{64'h00000004_FFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 1'b0, 1'b0, 32};
      vecs[6] = '{64'h00000005_00000000, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1};
      vecs[7] = '{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 32};

      #3;
      chk("rst.hs", {in_ready, out_valid}, 2'b10);
      chk("rst.out", {quotient, remainder, div_zero, overflow}, 66'd0);
      #9 rst_n = 1'b1;
      tick;

      foreach (vecs[i])
         run($sformatf("v%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
             vecs[i].dz, vecs[i].ov, vecs[i].lat, 0);

      // Backpressure with junk operands presented while busy; last result was 0/5.
      start("bp", 64'd1000, 32'd3);
      chk("bp.holdq", quotient, 32'd0);
      dividend = 64'd50; divisor = 32'd2; in_valid = 1'b1;
      chk("bp.busy", in_ready, 0);
      wait_done(cyc);
      chk("bp.lat", cyc, 32);
      out_ready = 1'b0;
      repeat (10) begin
         tick;
         chk("bp.stall", {out_valid, in_ready, quotient, remainder}, {2'b10, 32'd333, 32'd1});
      end
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("bp.idle", {out_valid, in_ready}, 2'b01);
      chk("bp.keep", {quotient, remainder}, {32'd333, 32'd1});
      tick;
      chk("bp.noacc", {out_valid, in_ready}, 2'b01);

      // Abort mid-computation at count 15.
      start("ra", 64'd3800, 32'd95);
      repeat (15) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("ra.hs", {in_ready, out_valid}, 2'b10);
      chk("ra.out", {quotient, remainder, div_zero, overflow}, 66'd0);
      #2 rst_n = 1'b1;
      tick;
      run("ra.nx", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32, 0);

      // Seeded vectors against a 64-bit reference, with random stall lengths.
      for (int i = 0; i < 150; i++) begin
         logic [63:0] dd, q64;
         logic [31:0] dv, hi;
         logic dz, ov;
         dv = (i % 10 == 0) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 1000) : $urandom);
         if (dv == 0) dv = (i % 10 == 0) ? 32'd0 : 32'd1;
         hi = (dv == 0 || i % 10 == 1) ? $urandom : ($urandom % dv);
         dd = {hi, 32'($urandom)};
         dz = (dv == 0);
         ov = !dz && (dd[63:32] >= dv);
         q64 = dz ? 64'd0 : dd / {32'd0, dv};
         if (dz || ov)
            run($sformatf("rn%0d", i), dd, dv, 32'hFFFFFFFF, dd[31:0], dz, ov, 1,
                int'($urandom_range(0, 3)));
         else
            run($sformatf("rn%0d", i), dd, dv, q64[31:0], 32'(dd - q64 * {32'd0, dv}), 1'b0,
                1'b0, 32, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
